// File: rtl/int_square.sv
// int_square: iterative shift-add integer squarer with remainder add.
// Rebuilds n = q*q + r from a (root, remainder) pair, one multiplier bit per
// cycle, LSB first. Inverse companion of the iterative integer square root.
//
// Ports:
//   clk_i           rising-edge clock
//   reset_i         synchronous, active-low reset
//   start_i         request, sampled only while idle
//   q_i             root operand (WIDTH/2 bits)
//   r_i             remainder operand (WIDTH/2+1 bits)
//   n_o             low WIDTH bits of q*q + r, held between completions
//   ovf_o           true sum >= 2^WIDTH
//   inconsistent_o  r_i > 2*q_i, i.e. not a valid isqrt pair
//   busy_o          FSM not idle
//   valid_o         one-cycle pulse when results update
module int_square #(
  parameter int WIDTH = 24
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [WIDTH/2-1:0] q_i,
  input  logic [WIDTH/2:0]   r_i,
  output logic [WIDTH-1:0]   n_o,
  output logic               ovf_o,
  output logic               inconsistent_o,
  output logic               busy_o,
  output logic               valid_o
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH:0]    acc_q, acc_d;
  logic [HALF-1:0]   mcand_q, mcand_d;
  logic [HALF-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              inc_r_q, inc_r_d;
  logic [WIDTH-1:0]  n_q, n_d;
  logic              ovf_q, ovf_d;
  logic              inc_q, inc_d;
  logic              valid_q, valid_d;

  logic [CW-1:0]     k;
  logic [WIDTH:0]    addend;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    inc_r_d  = inc_r_q;
    n_d      = n_q;
    ovf_d    = ovf_q;
    inc_d    = inc_q;
    valid_d  = 1'b0;

    // Bit position handled this cycle: counter runs down, bits go LSB first.
    k      = CW'(HALF - 1) - cnt_q;
    addend = {{(WIDTH + 1 - HALF){1'b0}}, mcand_q} << k;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          // Seeding the accumulator with r folds the remainder add into the
          // multiply; the extra top bit keeps the full sum without wrap.
          acc_d    = {{(WIDTH - HALF){1'b0}}, r_i};
          mcand_d  = q_i;
          mplier_d = q_i;
          cnt_d    = CW'(HALF - 1);
          inc_r_d  = (r_i > {q_i, 1'b0});
        end
      end
      RUN: begin
        if (mplier_q[k]) begin
          acc_d = acc_q + addend;
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        n_d     = acc_q[WIDTH-1:0];
        ovf_d   = acc_q[WIDTH];
        inc_d   = inc_r_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
      inc_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
      inc_q   <= inc_d;
      valid_q <= valid_d;
    end
  end

  // Multiplier bits and the consistency flag are always rewritten at capture
  // before use, so they need no reset.
  always_ff @(posedge clk_i) begin
    mplier_q <= mplier_d;
    inc_r_q  <= inc_r_d;
  end

  assign n_o            = n_q;
  assign ovf_o          = ovf_q;
  assign inconsistent_o = inc_q;
  assign valid_o        = valid_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_int_square.sv
module tb_int_square;

  localparam int WIDTH = 24;
  localparam int HALF  = WIDTH / 2;
  localparam int LAT   = HALF + 1;

  logic              clk_i;
  logic              reset_i;
  logic              start_i;
  logic [HALF-1:0]   q_i;
  logic [HALF:0]     r_i;
  logic [WIDTH-1:0]  n_o;
  logic              ovf_o;
  logic              inconsistent_o;
  logic              busy_o;
  logic              valid_o;

  int checks   = 0;
  int failures = 0;

  int_square #(.WIDTH(WIDTH)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .q_i            (q_i),
    .r_i            (r_i),
    .n_o            (n_o),
    .ovf_o          (ovf_o),
    .inconsistent_o (inconsistent_o),
    .busy_o         (busy_o),
    .valid_o        (valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: plain arithmetic on the mathematical definition.
  function automatic longint unsigned ref_sum(input longint unsigned q, input longint unsigned r);
    return q * q + r;
  endfunction

  function automatic longint unsigned ref_isqrt(input longint unsigned n);
    longint unsigned q = 0;
    while ((q + 1) * (q + 1) <= n) q++;
    return q;
  endfunction

  // Wait for valid_o, counting edges since the start sample; bounded.
  task automatic wait_valid(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!valid_o && edges < 40) begin
      if (busy_o) busy_cycles++;
      step();
      edges++;
    end
  endtask

  // Full transaction with latency, busy, result and pulse-width checks.
  task automatic do_op(input string tag, input logic [HALF-1:0] q, input logic [HALF:0] r);
    int edges, busy_cycles;
    longint unsigned s;
    s = ref_sum(q, r);
    q_i = q;
    r_i = r;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    // Changing operands after capture must not matter.
    q_i = HALF'($urandom);
    r_i = (HALF + 1)'($urandom);
    wait_valid(edges, busy_cycles);
    check({tag, ".latency"}, edges, LAT);
    check({tag, ".busy_cycles"}, busy_cycles, LAT);
    check({tag, ".busy_at_valid"}, busy_o, 0);
    check({tag, ".n"}, n_o, s & ((64'd1 << WIDTH) - 1));
    check({tag, ".ovf"}, ovf_o, (s >= (64'd1 << WIDTH)) ? 1 : 0);
    check({tag, ".inc"}, inconsistent_o, (r > 2 * longint'(q)) ? 1 : 0);
    step();
    check({tag, ".valid_pulse"}, valid_o, 0);
  endtask

  initial begin
    int edges, busy_cycles, vcount;
    longint unsigned n, q, r;

    reset_i = 1'b0;
    start_i = 1'b0;
    q_i = '0;
    r_i = '0;
    step();
    step();
    check("rst.n", n_o, 0);
    check("rst.ovf", ovf_o, 0);
    check("rst.inc", inconsistent_o, 0);
    check("rst.valid", valid_o, 0);
    check("rst.busy", busy_o, 0);
    reset_i = 1'b1;
    step();

    do_op("q3r2", 12'd3, 13'd2);
    do_op("maxvalid", 12'd4095, 13'd8190);
    do_op("ovf", 12'd4095, 13'd8191);
    do_op("q0r5", 12'd0, 13'd5);
    do_op("pure_sq", 12'd2000, 13'd0);

    // Starts while busy are ignored; start in the valid cycle is accepted.
    q_i = 12'd1000; r_i = 13'd0; start_i = 1'b1;
    step();                                   // edge S
    start_i = 1'b0;
    step(); step();                           // after S+2
    q_i = 12'd7; start_i = 1'b1;
    step();                                   // S+3 ignored
    start_i = 1'b0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin         // after S+4 .. S+11
      step();
      if (valid_o) vcount++;
    end
    start_i = 1'b1;
    step();                                   // S+12 ignored
    if (valid_o) vcount++;
    start_i = 1'b0;
    step();                                   // S+13
    check("busystart.valid", valid_o, 1);
    check("busystart.early_valid", vcount, 0);
    check("busystart.n", n_o, 1000000);
    q_i = 12'd7; r_i = 13'd0; start_i = 1'b1;
    step();                                   // accepted in valid cycle
    start_i = 1'b0;
    check("b2b.single_valid", valid_o, 0);
    wait_valid(edges, busy_cycles);
    check("b2b.latency", edges, LAT);
    check("b2b.n", n_o, 49);
    step();

    // Reset mid-operation aborts with no valid.
    q_i = 12'd4095; r_i = 13'd8190; start_i = 1'b1;
    step();                                   // S
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) step();       // after S+5
    reset_i = 1'b0;
    step();                                   // S+6
    check("abort.n", n_o, 0);
    check("abort.ovf", ovf_o, 0);
    check("abort.inc", inconsistent_o, 0);
    check("abort.valid", valid_o, 0);
    check("abort.busy", busy_o, 0);
    reset_i = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid_o) vcount++;
    end
    check("abort.no_valid", vcount, 0);
    do_op("after_abort", 12'd2, 13'd1);

    // Round trip through a reference integer square root.
    for (int i = 0; i < 200; i++) begin
      n = longint'($urandom_range(0, (1 << WIDTH) - 1));
      if (i == 0) n = 0;
      if (i == 1) n = (64'd1 << WIDTH) - 1;
      q = ref_isqrt(n);
      r = n - q * q;
      do_op("rt", HALF'(q), (HALF + 1)'(r));
      check("rt.n_eq_src", n_o, n);
    end

    // Random arbitrary pairs, including inconsistent ones.
    for (int i = 0; i < 20; i++) begin
      do_op("rand", HALF'($urandom), (HALF + 1)'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_square.md
Name: int_square

Overview:
- Iterative shift-add integer squarer with remainder add: computes n = q*q + r.
- Inverse companion of the iterative integer square-root unit. Rebuilds the radicand from a (root, remainder) pair for round-trip checking and for sqrt-based FP paths that need the squared root.
- Same control style as the sqrt unit: start pulse, IDLE/RUN/DONE FSM, bit counter, one-cycle valid pulse.

Parameters:
- WIDTH, 24, radicand width. Must be even and ≥ 4. Root is WIDTH/2 bits; remainder is WIDTH/2+1 bits.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  synchronous, active-low reset.
- start_i  input  1  request. Sampled only in IDLE.
- q_i  input  WIDTH/2  root operand.
- r_i  input  WIDTH/2+1  remainder operand.
- n_o  output  WIDTH  result q*q + r, low WIDTH bits.
- ovf_o  output  1  true sum ≥ 2^WIDTH.
- inconsistent_o  output  1  r_i > 2*q_i (not a valid isqrt pair). Result is still computed.
- busy_o  output  1  FSM not in IDLE.
- valid_o  output  1  one-cycle pulse; results updated.

Behaviour:
- Reset is synchronous. When reset_i is low at a rising edge:
  - state goes to IDLE;
  - acc, mcand, cnt are cleared;
  - n_o, ovf_o, inconsistent_o and valid_o go to 0.
  - Reset mid-operation aborts the operation. No valid_o is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start_i=1. Otherwise stay in IDLE.
  - RUN→DONE when cnt==0. Otherwise stay in RUN.
  - DONE→IDLE unconditionally.
- Capture (edge S: start_i sampled in IDLE):
  - acc(WIDTH+1 bits) ← zero-extended r_i.
  - mcand ← q_i; mplier ← q_i; cnt ← WIDTH/2-1.
  - inc_r ← (r_i > {q_i,0}).
- RUN iteration (edges S+1 .. S+WIDTH/2):
  - k = WIDTH/2-1-cnt, i.e. LSB first.
  - If mplier[k]: acc ← acc + (mcand << k), using a WIDTH+1 bit add.
  - cnt ← cnt-1.
  - The edge where cnt==0 performs the last add and moves to DONE.
- DONE (edge S+WIDTH/2+1):
  - n_o ← acc[WIDTH-1:0]; ovf_o ← acc[WIDTH]; inconsistent_o ← inc_r.
  - valid_o ← 1 for exactly one cycle; state ← IDLE.
- Latency: WIDTH/2+1 edges from start sample to valid_o high. For WIDTH=24 that is 13.
- Throughput: start_i may be high in the cycle valid_o is high (state already IDLE). Back-to-back period is WIDTH/2+2 cycles.
- start_i while busy_o=1 is ignored. Operands are not re-sampled. In-flight q/r come only from the capture registers, so input changes after S have no effect.
- n_o, ovf_o and inconsistent_o hold their value between completions. They change only at the DONE edge or on reset.
- busy_o = (state != IDLE), combinational from the state register.
- Width bound: the maximum sum (2^(W/2)-1)^2 + 2^(W/2+1)-1 < 2^(W+1), so acc never wraps.
- Valid pairs (r ≤ 2q) never set ovf_o.
- Edge cases:
  - q_i=0 gives no adds; n_o = r_i.
  - r_i=0 gives a pure square.

Test Plan (WIDTH=24):
- q=3, r=2, start one cycle → valid_o at start edge+13; n_o=11, ovf_o=0, inconsistent_o=0; busy_o high for 13 cycles.
- q=4095, r=8190 → n_o=16777215, ovf_o=0, inconsistent_o=0.
- q=4095, r=8191 → n_o=0, ovf_o=1, inconsistent_o=1. Also q=0, r=5 → n_o=5, inconsistent_o=1.
- Start q=1000, r=0. Pulse start_i with q=7 at edges S+3 and S+12 → n_o=1000000, single valid_o. Start re-asserted in the valid cycle is accepted and yields 49 thirteen edges later.
- Start q=4095, r=8190, assert reset_i=0 at edge S+6 → all outputs 0, state IDLE, no valid_o. A following start q=2, r=1 → n_o=5.
- Round trip: 200 random n feed int_sqrt; its (q,r) feed this block → n_o == n, ovf_o=0, inconsistent_o=0 for all.
